// File: rtl/regs_pkg.sv
// Shared definitions for the parametrised register bank: fixed register indices,
// write-mode and post-modify encodings, and small decode helpers.
package regs_pkg;

    localparam int REG_AX = 0;
    localparam int REG_CX = 1;
    localparam int REG_DX = 2;
    localparam int REG_BX = 3;
    localparam int REG_SP = 4;
    localparam int REG_BP = 5;
    localparam int REG_SI = 6;
    localparam int REG_DI = 7;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LO   = 2'b01,
        WM_HI   = 2'b10,
        WM_NONE = 2'b11
    } wr_mode_e;

    typedef enum logic [1:0] {
        PM_PUSH = 2'b00,
        PM_POP  = 2'b01,
        PM_STR  = 2'b10,
        PM_SI   = 2'b11
    } pm_op_e;

    function automatic logic pm_moves_sp(input logic [1:0] op);
        return (op == PM_PUSH) || (op == PM_POP);
    endfunction

    function automatic logic pm_moves_si(input logic [1:0] op);
        return (op == PM_STR) || (op == PM_SI);
    endfunction

    function automatic logic pm_moves_di(input logic [1:0] op);
        return (op == PM_STR);
    endfunction

endpackage

// File: rtl/banco_registros_p_if.sv
// Request/response bundle between decode/control, the ALU/AGU and the register bank.
interface banco_registros_p_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 3
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [1:0]        wr_mode;
    logic              hi_src;
    logic [DATA_W-1:0] data_in;
    logic              pm_en;
    logic [1:0]        pm_op;
    logic              pm_byte;
    logic              dir;
    logic [AW-1:0]     rd_addr_a;
    logic [AW-1:0]     rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] si;
    logic [DATA_W-1:0] di;
    logic              wrap;

    modport master (
        output wr_en, wr_addr, wr_mode, hi_src, data_in,
        output pm_en, pm_op, pm_byte, dir,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, sp, si, di, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, hi_src, data_in,
        input  pm_en, pm_op, pm_byte, dir,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, sp, si, di, wrap
    );

endinterface

// File: rtl/regs_postmod.sv
// Combinational next-value and boundary-crossing calculation for SP, SI and DI.
module regs_postmod
    import regs_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              pm_en,
    input  logic [1:0]        pm_op,
    input  logic              pm_byte,
    input  logic              dir,
    input  logic [DATA_W-1:0] sp_cur,
    input  logic [DATA_W-1:0] si_cur,
    input  logic [DATA_W-1:0] di_cur,
    output logic [DATA_W-1:0] sp_nxt,
    output logic [DATA_W-1:0] si_nxt,
    output logic [DATA_W-1:0] di_nxt,
    output logic              sp_upd,
    output logic              si_upd,
    output logic              di_upd,
    output logic              sp_wrap,
    output logic              si_wrap,
    output logic              di_wrap
);

    localparam logic [DATA_W:0] WORD_STEP = (DATA_W + 1)'(DATA_W / 8);
    localparam logic [DATA_W:0] BYTE_STEP = (DATA_W + 1)'(1);

    logic [DATA_W:0] str_step_s;
    logic [DATA_W:0] sp_res_s;
    logic [DATA_W:0] si_res_s;
    logic [DATA_W:0] di_res_s;

    // The extra top bit is the carry on increment and the borrow on decrement.
    function automatic logic [DATA_W:0] step_ptr(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W:0]   step,
                                                 input logic              down);
        logic [DATA_W:0] ext;
        ext = {1'b0, cur};
        if (down) begin
            return ext - step;
        end else begin
            return ext + step;
        end
    endfunction

    // Pointer arithmetic and per-pointer update enables.
    always_comb begin
        str_step_s = WORD_STEP;
        if (pm_byte) begin
            str_step_s = BYTE_STEP;
        end else begin
            str_step_s = WORD_STEP;
        end
        sp_res_s = step_ptr(sp_cur, WORD_STEP, pm_op == PM_PUSH);
        si_res_s = step_ptr(si_cur, str_step_s, dir);
        di_res_s = step_ptr(di_cur, str_step_s, dir);
        sp_upd   = pm_en && pm_moves_sp(pm_op);
        si_upd   = pm_en && pm_moves_si(pm_op);
        di_upd   = pm_en && pm_moves_di(pm_op);
    end

    assign sp_nxt  = sp_res_s[DATA_W-1:0];
    assign si_nxt  = si_res_s[DATA_W-1:0];
    assign di_nxt  = di_res_s[DATA_W-1:0];
    assign sp_wrap = sp_res_s[DATA_W];
    assign si_wrap = si_res_s[DATA_W];
    assign di_wrap = di_res_s[DATA_W];

endmodule

// File: rtl/banco_registros_p.sv
// Parametrised GP/pointer register file: storage, byte-merge writes, SP/SI/DI
// post-modify with wrap detection, explicit-write priority and two read ports.
module banco_registros_p
    import regs_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input logic                clk,
    input logic                reset,
    banco_registros_p_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wrap_q;
    logic              wrap_d;

    logic              wr_valid_s;
    logic [DATA_W-1:0] wr_old_s;
    logic [DATA_W-1:0] wr_merged_s;
    logic              hit_sp_s;
    logic              hit_si_s;
    logic              hit_di_s;
    logic [DATA_W-1:0] sp_nxt_s;
    logic [DATA_W-1:0] si_nxt_s;
    logic [DATA_W-1:0] di_nxt_s;
    logic              sp_upd_s;
    logic              si_upd_s;
    logic              di_upd_s;
    logic              sp_wrap_s;
    logic              si_wrap_s;
    logic              di_wrap_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [1:0]        mode,
                                                     input logic              hi_sel);
        logic [DATA_W-1:0] res;
        logic [7:0]        hb;
        res = old_v;
        hb  = hi_sel ? new_v[15:8] : new_v[7:0];
        case (mode)
            WM_FULL: res = new_v;
            WM_LO:   res[7:0] = new_v[7:0];
            WM_HI:   res[15:8] = hb;
            default: res = old_v;
        endcase
        return res;
    endfunction

    regs_postmod #(
        .DATA_W (DATA_W)
    ) u_postmod (
        .pm_en   (bus.pm_en),
        .pm_op   (bus.pm_op),
        .pm_byte (bus.pm_byte),
        .dir     (bus.dir),
        .sp_cur  (regs_q[REG_SP]),
        .si_cur  (regs_q[REG_SI]),
        .di_cur  (regs_q[REG_DI]),
        .sp_nxt  (sp_nxt_s),
        .si_nxt  (si_nxt_s),
        .di_nxt  (di_nxt_s),
        .sp_upd  (sp_upd_s),
        .si_upd  (si_upd_s),
        .di_upd  (di_upd_s),
        .sp_wrap (sp_wrap_s),
        .si_wrap (si_wrap_s),
        .di_wrap (di_wrap_s)
    );

    // Decode the explicit write: validity, old contents and merged result.
    always_comb begin
        wr_valid_s = 1'b0;
        wr_old_s   = {DATA_W{1'b0}};
        if (bus.wr_en && (bus.wr_mode != WM_NONE) && (int'(bus.wr_addr) < NREG)) begin
            wr_valid_s = 1'b1;
            wr_old_s   = regs_q[bus.wr_addr];
        end else begin
            wr_valid_s = 1'b0;
            wr_old_s   = {DATA_W{1'b0}};
        end
        wr_merged_s = merge_word(wr_old_s, bus.data_in, bus.wr_mode, bus.hi_src);
        hit_sp_s    = wr_valid_s && (int'(bus.wr_addr) == REG_SP);
        hit_si_s    = wr_valid_s && (int'(bus.wr_addr) == REG_SI);
        hit_di_s    = wr_valid_s && (int'(bus.wr_addr) == REG_DI);
    end

    // Next register values: an explicit write overrides a same-register post-modify.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_valid_s && (int'(bus.wr_addr) == i)) begin
                regs_d[i] = wr_merged_s;
            end else if ((i == REG_SP) && sp_upd_s) begin
                regs_d[i] = sp_nxt_s;
            end else if ((i == REG_SI) && si_upd_s) begin
                regs_d[i] = si_nxt_s;
            end else if ((i == REG_DI) && di_upd_s) begin
                regs_d[i] = di_nxt_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        wrap_d = (sp_upd_s && sp_wrap_s && !hit_sp_s) ||
                 (si_upd_s && si_wrap_s && !hit_si_s) ||
                 (di_upd_s && di_wrap_s && !hit_di_s);
    end

    // Read muxes; only the explicit write is forwarded, never post-modify results.
    always_comb begin
        rd_a_s = {DATA_W{1'b0}};
        rd_b_s = {DATA_W{1'b0}};
        if ((BYPASS != 0) && wr_valid_s && (bus.rd_addr_a == bus.wr_addr)) begin
            rd_a_s = wr_merged_s;
        end else if (int'(bus.rd_addr_a) < NREG) begin
            rd_a_s = regs_q[bus.rd_addr_a];
        end else begin
            rd_a_s = {DATA_W{1'b0}};
        end
        if ((BYPASS != 0) && wr_valid_s && (bus.rd_addr_b == bus.wr_addr)) begin
            rd_b_s = wr_merged_s;
        end else if (int'(bus.rd_addr_b) < NREG) begin
            rd_b_s = regs_q[bus.rd_addr_b];
        end else begin
            rd_b_s = {DATA_W{1'b0}};
        end
    end

    // Storage and wrap pulse; reset discards any request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.rd_data_a = rd_a_s;
    assign bus.rd_data_b = rd_b_s;
    assign bus.sp        = regs_q[REG_SP];
    assign bus.si        = regs_q[REG_SI];
    assign bus.di        = regs_q[REG_DI];
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_banco_registros_p.sv
// Self-checking bench: three register-bank configurations driven by directed and
// random requests, compared against an integer-arithmetic reference model.
module tb_banco_registros_p;

    typedef struct {
        bit          reset;
        bit          wr_en;
        int          wr_addr;
        int          wr_mode;
        bit          hi_src;
        logic [63:0] data;
        bit          pm_en;
        int          pm_op;
        bit          pm_byte;
        bit          dir;
        int          ra;
        int          rb;
    } stim_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_c;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model 0: 16-bit/8 registers (DUTs 0 and 1). Model 1: 32-bit/16 registers (DUT 2).
    logic [63:0] mdl [2][16];
    bit          mwrap [2];

    always #5 clk = ~clk;

    banco_registros_p_if #(.DATA_W(16), .AW(3)) if0 ();
    banco_registros_p_if #(.DATA_W(16), .AW(3)) if1 ();
    banco_registros_p_if #(.DATA_W(32), .AW(4)) if2 ();

    banco_registros_p #(.DATA_W(16), .NREG(8), .BYPASS(1)) dut0 (
        .clk (clk), .reset (rst_a), .bus (if0.slave));
    banco_registros_p #(.DATA_W(16), .NREG(8), .BYPASS(0)) dut1 (
        .clk (clk), .reset (rst_a), .bus (if1.slave));
    banco_registros_p #(.DATA_W(32), .NREG(16), .BYPASS(1)) dut2 (
        .clk (clk), .reset (rst_c), .bus (if2.slave));

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic int nreg_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic logic [63:0] mask_of(input int k);
        return (64'd1 << width_of(k)) - 64'd1;
    endfunction

    function automatic bit write_valid(input int k, input stim_t s);
        return s.wr_en && (s.wr_mode != 3) && (s.wr_addr < nreg_of(k));
    endfunction

    function automatic logic [63:0] merge_m(input int k, input logic [63:0] old, input stim_t s);
        logic [63:0] hb;
        hb = s.hi_src ? ((s.data >> 8) & 64'hFF) : (s.data & 64'hFF);
        case (s.wr_mode)
            0:       return s.data & mask_of(k);
            1:       return (old & ~64'hFF) | (s.data & 64'hFF);
            2:       return (old & ~64'hFF00) | (hb << 8);
            default: return old;
        endcase
    endfunction

    function automatic logic [63:0] exp_read(input int k, input bit byp, input stim_t s, input int ra);
        if (byp && write_valid(k, s) && (ra == s.wr_addr)) return merge_m(k, mdl[k][ra], s);
        if (ra < nreg_of(k)) return mdl[k][ra];
        return 64'd0;
    endfunction

    // Reference behaviour of one clock edge, using signed true results for wrap.
    task automatic model_clock(input int k, input stim_t s);
        logic [63:0] nxt [16];
        int          tg [$];
        longint      dl [$];
        bit          w;
        longint      span;
        longint      t;
        int          bytes;
        int          step;
        w     = 1'b0;
        span  = longint'(1) << width_of(k);
        bytes = width_of(k) / 8;
        for (int i = 0; i < 16; i++) nxt[i] = mdl[k][i];
        if (s.pm_en) begin
            step = s.pm_byte ? 1 : bytes;
            case (s.pm_op)
                0: begin tg.push_back(4); dl.push_back(-bytes); end
                1: begin tg.push_back(4); dl.push_back(bytes); end
                2: begin
                    tg.push_back(6); dl.push_back(s.dir ? -step : step);
                    tg.push_back(7); dl.push_back(s.dir ? -step : step);
                end
                default: begin tg.push_back(6); dl.push_back(s.dir ? -step : step); end
            endcase
        end
        foreach (tg[i]) begin
            if (!(write_valid(k, s) && (s.wr_addr == tg[i]))) begin
                t = longint'(mdl[k][tg[i]]) + dl[i];
                if ((t < 0) || (t >= span)) w = 1'b1;
                nxt[tg[i]] = 64'(t) & mask_of(k);
            end
        end
        if (write_valid(k, s)) nxt[s.wr_addr] = merge_m(k, mdl[k][s.wr_addr], s);
        if (s.reset) begin
            for (int i = 0; i < 16; i++) nxt[i] = 64'd0;
            w = 1'b0;
        end
        for (int i = 0; i < 16; i++) mdl[k][i] = nxt[i];
        mwrap[k] = w;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.reset = 1'b0; s.wr_en = 1'b0; s.wr_addr = 0; s.wr_mode = 3; s.hi_src = 1'b0;
        s.data = 64'd0; s.pm_en = 1'b0; s.pm_op = 0; s.pm_byte = 1'b0; s.dir = 1'b0;
        s.ra = 0; s.rb = 0;
        return s;
    endfunction

    function automatic stim_t wr(input int addr, input int mode, input bit hi, input logic [63:0] d);
        stim_t s;
        s = idle();
        s.wr_en = 1'b1; s.wr_addr = addr; s.wr_mode = mode; s.hi_src = hi; s.data = d;
        s.ra = addr; s.rb = addr;
        return s;
    endfunction

    function automatic stim_t pm(input int op, input bit bstep, input bit d);
        stim_t s;
        s = idle();
        s.pm_en = 1'b1; s.pm_op = op; s.pm_byte = bstep; s.dir = d; s.ra = 4; s.rb = 6;
        return s;
    endfunction

    function automatic stim_t rand_stim(input int k);
        stim_t       s;
        logic [63:0] m;
        int          n;
        int          ptrs [3];
        ptrs = '{4, 6, 7};
        m = mask_of(k);
        n = nreg_of(k);
        s.reset   = ($urandom_range(0, 79) == 0);
        s.wr_en   = ($urandom_range(0, 4) < 2);
        s.wr_addr = ($urandom_range(0, 1) == 1) ? ptrs[$urandom_range(0, 2)] : int'($urandom_range(0, n - 1));
        s.wr_mode = int'($urandom_range(0, 3));
        s.hi_src  = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 3))
            0:       s.data = 64'($urandom_range(0, 5));
            1:       s.data = m - 64'($urandom_range(0, 5));
            default: s.data = {$urandom, $urandom} & m;
        endcase
        s.pm_en   = ($urandom_range(0, 1) == 1);
        s.pm_op   = int'($urandom_range(0, 3));
        s.pm_byte = ($urandom_range(0, 1) == 1);
        s.dir     = ($urandom_range(0, 1) == 1);
        s.ra      = int'($urandom_range(0, n - 1));
        s.rb      = int'($urandom_range(0, n - 1));
        return s;
    endfunction

    task automatic drive_all(input stim_t a, input stim_t c);
        rst_a = a.reset;
        if0.wr_en = a.wr_en; if0.wr_addr = 3'(a.wr_addr); if0.wr_mode = 2'(a.wr_mode);
        if0.hi_src = a.hi_src; if0.data_in = a.data[15:0]; if0.pm_en = a.pm_en;
        if0.pm_op = 2'(a.pm_op); if0.pm_byte = a.pm_byte; if0.dir = a.dir;
        if0.rd_addr_a = 3'(a.ra); if0.rd_addr_b = 3'(a.rb);
        if1.wr_en = a.wr_en; if1.wr_addr = 3'(a.wr_addr); if1.wr_mode = 2'(a.wr_mode);
        if1.hi_src = a.hi_src; if1.data_in = a.data[15:0]; if1.pm_en = a.pm_en;
        if1.pm_op = 2'(a.pm_op); if1.pm_byte = a.pm_byte; if1.dir = a.dir;
        if1.rd_addr_a = 3'(a.ra); if1.rd_addr_b = 3'(a.rb);
        rst_c = c.reset;
        if2.wr_en = c.wr_en; if2.wr_addr = 4'(c.wr_addr); if2.wr_mode = 2'(c.wr_mode);
        if2.hi_src = c.hi_src; if2.data_in = c.data[31:0]; if2.pm_en = c.pm_en;
        if2.pm_op = 2'(c.pm_op); if2.pm_byte = c.pm_byte; if2.dir = c.dir;
        if2.rd_addr_a = 4'(c.ra); if2.rd_addr_b = 4'(c.rb);
    endtask

    task automatic check_outputs(input stim_t a, input stim_t c);
        check_value("d0_rd_a", if0.rd_data_a, exp_read(0, 1'b1, a, a.ra));
        check_value("d0_rd_b", if0.rd_data_b, exp_read(0, 1'b1, a, a.rb));
        check_value("d0_sp", if0.sp, mdl[0][4]);
        check_value("d0_si", if0.si, mdl[0][6]);
        check_value("d0_di", if0.di, mdl[0][7]);
        check_value("d0_wrap", if0.wrap, mwrap[0]);
        check_value("d1_rd_a", if1.rd_data_a, exp_read(0, 1'b0, a, a.ra));
        check_value("d1_rd_b", if1.rd_data_b, exp_read(0, 1'b0, a, a.rb));
        check_value("d1_sp", if1.sp, mdl[0][4]);
        check_value("d1_wrap", if1.wrap, mwrap[0]);
        check_value("d2_rd_a", if2.rd_data_a, exp_read(1, 1'b1, c, c.ra));
        check_value("d2_rd_b", if2.rd_data_b, exp_read(1, 1'b1, c, c.rb));
        check_value("d2_sp", if2.sp, mdl[1][4]);
        check_value("d2_si", if2.si, mdl[1][6]);
        check_value("d2_di", if2.di, mdl[1][7]);
        check_value("d2_wrap", if2.wrap, mwrap[1]);
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
    task automatic step_begin(input stim_t a, input stim_t c);
        drive_all(a, c);
        #2;
        check_outputs(a, c);
    endtask

    task automatic step_end(input stim_t a, input stim_t c);
        model_clock(0, a);
        model_clock(1, c);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input stim_t a, input stim_t c);
        step_begin(a, c);
        step_end(a, c);
    endtask

    initial begin
        stim_t z;
        stim_t s;
        z = idle();
        s = idle();
        s.reset = 1'b1;
        drive_all(s, s);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mdl[k][i] = 64'd0;
            mwrap[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_sp16", if0.sp, 64'h0);
        check_value("rst_sp32", if2.sp, 64'h0);
        step(z, z);

        // Byte-merge writes.
        step(wr(0, 0, 1'b0, 64'h1234), z);
        step(wr(3, 1, 1'b0, 64'hAB), z);
        step(wr(1, 2, 1'b0, 64'h00CD), z);
        s = idle(); s.ra = 0; s.rb = 3;
        step_begin(s, z);
        check_value("ax_full", if0.rd_data_a, 64'h1234);
        check_value("bx_low", if0.rd_data_b, 64'h00AB);
        step_end(s, z);
        s.ra = 1;
        step_begin(s, z);
        check_value("cx_high", if0.rd_data_a, 64'hCD00);
        step_end(s, z);

        // Push/pop around zero.
        step(wr(4, 0, 1'b0, 64'h0004), z);
        step(pm(0, 1'b0, 1'b0), z);
        check_value("push1_sp", if0.sp, 64'h0002);
        check_value("push1_wrap", if0.wrap, 64'h0);
        step(pm(0, 1'b0, 1'b0), z);
        check_value("push2_sp", if0.sp, 64'h0000);
        check_value("push2_wrap", if0.wrap, 64'h0);
        step(pm(0, 1'b0, 1'b0), z);
        check_value("push3_sp", if0.sp, 64'hFFFE);
        check_value("push3_wrap", if0.wrap, 64'h1);
        step(pm(1, 1'b0, 1'b0), z);
        check_value("pop_sp", if0.sp, 64'h0000);
        check_value("pop_wrap", if0.wrap, 64'h1);

        // String steps.
        step(wr(6, 0, 1'b0, 64'h0010), z);
        step(wr(7, 0, 1'b0, 64'h0020), z);
        step(pm(2, 1'b0, 1'b0), z);
        check_value("str_w_si", if0.si, 64'h0012);
        check_value("str_w_di", if0.di, 64'h0022);
        step(pm(2, 1'b1, 1'b1), z);
        check_value("str_b_si", if0.si, 64'h0011);
        check_value("str_b_di", if0.di, 64'h0021);

        // Collisions: explicit write wins, dropped step does not raise wrap.
        s = wr(4, 0, 1'b0, 64'h5555); s.pm_en = 1'b1; s.pm_op = 0;
        step(s, z);
        check_value("col_sp", if0.sp, 64'h5555);
        check_value("col_wrap", if0.wrap, 64'h0);
        s = wr(6, 0, 1'b0, 64'h0777); s.pm_en = 1'b1; s.pm_op = 2;
        step(s, z);
        check_value("col_si", if0.si, 64'h0777);
        check_value("col_di", if0.di, 64'h0023);

        // Forwarding versus stored-value read.
        s = wr(0, 0, 1'b0, 64'hBEEF);
        step_begin(s, z);
        check_value("byp1_same", if0.rd_data_a, 64'hBEEF);
        check_value("byp0_same", if1.rd_data_a, 64'h1234);
        step_end(s, z);
        check_value("byp0_next", if1.rd_data_a, 64'hBEEF);

        // Wide configuration.
        step(z, pm(0, 1'b0, 1'b0));
        check_value("w32_push_sp", if2.sp, 64'hFFFFFFFC);
        check_value("w32_push_wrap", if2.wrap, 64'h1);
        step(z, wr(12, 0, 1'b0, 64'h89ABCDEF));
        step(z, wr(12, 2, 1'b1, 64'h00005A00));
        s = idle(); s.ra = 12; s.rb = 4;
        step_begin(z, s);
        check_value("w32_hi_r12", if2.rd_data_a, 64'h89AB5AEF);
        step_end(z, s);
        s = pm(0, 1'b0, 1'b0); s.reset = 1'b1;
        step(z, s);
        check_value("w32_rst_sp", if2.sp, 64'h0);
        check_value("w32_rst_wrap", if2.wrap, 64'h0);
        s = idle(); s.ra = 12; s.rb = 0;
        step_begin(z, s);
        check_value("w32_rst_r12", if2.rd_data_a, 64'h0);
        step_end(z, s);

        // Random traffic on all three instances.
        for (int n = 0; n < 800; n++) begin
            step(rand_stim(0), rand_stim(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
